// File: rtl/otp_keypad_entry.sv
// 4x4 active-low keypad scanner with per-scan debounce. Each accepted press
// produces one user_latch strobe carrying its digit code to the OTP authentication FSM.
module otp_keypad_entry #(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] user_digit,
  output logic       user_latch,
  output logic       key_down,
  output logic       multi_key
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_DONE = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next, count_inc;
  logic [3:0]       candidate, candidate_next;
  logic [3:0]       row_meta, row_sync;
  logic [SW-1:0]    slot;
  logic [1:0]       col_idx;
  logic [3:0][3:0]  scan_img;
  logic             scan_done;
  logic [4:0]       hits;
  logic [3:0]       hit_code;
  logic             is_empty, is_single, is_multi;
  logic             strobe;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Rows come from mechanical switches with no relation to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // col_out trails col_idx by a cycle; with the synchronizer that leaves
  // the rows settled by the last slot of each column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot      <= '0;
      col_idx   <= 2'd0;
      col_out   <= 4'hF;
      scan_img  <= '0;
      scan_done <= 1'b0;
    end else if (!enable) begin
      slot      <= '0;
      col_idx   <= 2'd0;
      col_out   <= 4'hF;
      scan_img  <= '0;
      scan_done <= 1'b0;
    end else begin
      col_out   <= ~(4'b0001 << col_idx);
      scan_done <= 1'b0;
      if (slot == SLOT_LAST) begin
        slot              <= '0;
        col_idx           <= col_idx + 2'd1;
        scan_img[col_idx] <= ~row_sync;
        scan_done         <= (col_idx == 2'd3);
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  always_comb begin
    hits     = 5'd0;
    hit_code = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (scan_img[c][r]) begin
          hits     = hits + 5'd1;
          hit_code = key_code(2'(r), 2'(c));
        end
      end
    end
  end

  assign is_empty  = (hits == 5'd0);
  assign is_single = (hits == 5'd1);
  assign is_multi  = (hits >= 5'd2);
  assign count_inc = count + COUNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      candidate <= 4'h0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      candidate <= candidate_next;
    end
  end

  // One counter serves both press and release debounce; only one is live at a time.
  always_comb begin
    state_next     = state;
    count_next     = count;
    candidate_next = candidate;
    strobe         = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      count_next = '0;
    end else if (scan_done) begin
      case (state)
        IDLE: begin
          if (is_single) begin
            candidate_next = hit_code;
            if (COUNT_ONE == COUNT_DONE) begin
              state_next = PRESSED;
              count_next = '0;
              strobe     = 1'b1;
            end else begin
              state_next = DEBOUNCE;
              count_next = COUNT_ONE;
            end
          end
        end
        DEBOUNCE: begin
          if (is_single && hit_code == candidate) begin
            if (count_inc == COUNT_DONE) begin
              state_next = PRESSED;
              count_next = '0;
              strobe     = 1'b1;
            end else begin
              count_next = count_inc;
            end
          end else if (is_single) begin
            candidate_next = hit_code;
            count_next     = COUNT_ONE;
          end else begin
            state_next = IDLE;
            count_next = '0;
          end
        end
        PRESSED: begin
          if (is_empty) begin
            if (COUNT_ONE == COUNT_DONE) begin
              state_next = IDLE;
              count_next = '0;
            end else begin
              state_next = RELEASE;
              count_next = COUNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (is_empty) begin
            if (count_inc == COUNT_DONE) begin
              state_next = IDLE;
              count_next = '0;
            end else begin
              count_next = count_inc;
            end
          end else begin
            state_next = PRESSED;
            count_next = '0;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_down = (state == PRESSED) || (state == RELEASE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      user_digit <= 4'h0;
      user_latch <= 1'b0;
      multi_key  <= 1'b0;
    end else begin
      user_latch <= strobe;
      if (strobe) begin
        user_digit <= hit_code;
      end
      if (!enable) begin
        multi_key <= 1'b0;
      end else if (scan_done) begin
        multi_key <= is_multi;
      end
    end
  end

endmodule

// File: tb/tb_otp_keypad_entry.sv
// Bench for otp_keypad_entry: keypad matrix model, scan-level behavioural
// reference checked every cycle, directed scenarios then random key traffic.
module tb_otp_keypad_entry;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * SD;
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  row_in, col_out, user_digit;
  logic        user_latch, key_down, multi_key;

  int total = 0;
  int bad = 0;
  int latches = 0;

  always #5 clk = ~clk;

  // A row reads low when a pressed key in it sits on the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  otp_keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .row_in(row_in),
    .col_out(col_out), .user_digit(user_digit), .user_latch(user_latch),
    .key_down(key_down), .multi_key(multi_key)
  );

  // Reference: time since scanning started decides column and sample points;
  // each finished scan feeds a run-length press/release debouncer.
  int          m_t, m_run_len, m_rel_len;
  logic [15:0] m_d1, m_d2, m_img;
  logic [3:0]  m_run_code;
  bit          m_held;
  logic [3:0]  exp_col, exp_digit;
  bit          exp_latch, exp_multi;

  always @(posedge clk or negedge reset) begin : model
    int hits, col;
    logic [3:0] code;
    if (!reset) begin
      m_t = 0; m_run_len = 0; m_rel_len = 0; m_held = 0; m_run_code = 4'h0;
      m_d1 = 16'h0; m_d2 = 16'h0; m_img = 16'h0;
      exp_col = 4'hF; exp_digit = 4'h0; exp_latch = 0; exp_multi = 0;
    end else begin
      exp_latch = 0;
      if (!enable) begin
        m_t = 0; exp_col = 4'hF; exp_multi = 0;
        m_held = 0; m_run_len = 0; m_rel_len = 0;
      end else begin
        if (m_t > 0 && (m_t % SCAN) == 0) begin
          hits = 0; code = 4'h0;
          for (int i = 0; i < 16; i++) if (m_img[i]) begin hits++; code = KEYMAP[i]; end
          exp_multi = (hits >= 2);
          if (!m_held) begin
            if (hits == 1) begin
              if (m_run_len > 0 && code == m_run_code) m_run_len++;
              else begin m_run_code = code; m_run_len = 1; end
              if (m_run_len >= DB) begin
                m_held = 1; m_run_len = 0; m_rel_len = 0;
                exp_latch = 1; exp_digit = code;
              end
            end else m_run_len = 0;
          end else begin
            if (hits == 0) begin
              m_rel_len++;
              if (m_rel_len >= DB) begin m_held = 0; m_rel_len = 0; end
            end else m_rel_len = 0;
          end
        end
        col = (m_t / SD) % 4;
        exp_col = ~(4'b0001 << col);
        if ((m_t % SD) == SD - 1)
          for (int r = 0; r < 4; r++) m_img[r*4 + col] = m_d2[r*4 + col];
        m_t++;
      end
      m_d2 = m_d1;
      m_d1 = keys;
    end
  end

  task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (reset) begin
      check_output("col_out", col_out, exp_col);
      check_output("user_digit", user_digit, exp_digit);
      check_output("user_latch", {3'b0, user_latch}, {3'b0, exp_latch});
      check_output("key_down", {3'b0, key_down}, {3'b0, m_held});
      check_output("multi_key", {3'b0, multi_key}, {3'b0, exp_multi});
      if (user_latch) latches++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align();
    int n;
    n = 0;
    while ((m_t % SCAN) != 1 && n < 3 * SCAN) begin step(); n++; end
    check_output("scan_align", {3'b0, ((m_t % SCAN) == 1)}, 4'h1);
  endtask

  task automatic apply_stimulus(input logic [15:0] k, input int n);
    keys = k;
    run(n);
  endtask

  initial begin : stim
    int lat, fall;
    logic [15:0] pat;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run(40);

    // clean press of r1c1
    align();
    latches = 0; lat = -1; keys = 16'h0020;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (user_latch && lat < 0) lat = i;
    end
    check_output("press_strobes", 4'(latches), 4'h1);
    check_output("press_digit", user_digit, 4'h5);
    check_output("press_latency_ok", {3'b0, (lat > 0 && lat <= 48)}, 4'h1);
    align();
    keys = 16'h0; fall = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (!key_down && fall < 0) fall = i;
    end
    check_output("release_delay_ok", {3'b0, (fall >= 32)}, 4'h1);

    // asynchronous reset in the middle of a scan
    keys = 16'h0001;
    run(21);
    #2 reset = 1'b0;
    #1;
    check_output("rst_col_out", col_out, 4'hF);
    check_output("rst_user_digit", user_digit, 4'h0);
    check_output("rst_user_latch", {3'b0, user_latch}, 4'h0);
    check_output("rst_key_down", {3'b0, key_down}, 4'h0);
    check_output("rst_multi_key", {3'b0, multi_key}, 4'h0);
    keys = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check_output("col_sequence", col_out, ~(4'b0001 << (i / 4)));
    end
    run(40);

    // bounce on r3c1, then a stable hold
    align();
    latches = 0;
    for (int i = 0; i < 40; i++) begin
      keys = (((i / 3) % 2) == 1) ? 16'h2000 : 16'h0000;
      step();
    end
    check_output("bounce_no_strobe", 4'(latches), 4'h0);
    apply_stimulus(16'h2000, 80);
    check_output("bounce_strobes", 4'(latches), 4'h1);
    check_output("bounce_digit", user_digit, 4'h0);
    align();
    latches = 0;
    apply_stimulus(16'h0000, 16);
    apply_stimulus(16'h2000, 48);
    apply_stimulus(16'h0000, 80);
    check_output("glitch_no_strobe", 4'(latches), 4'h0);
    check_output("glitch_released", {3'b0, key_down}, 4'h0);

    // two keys together, then drop one
    align();
    latches = 0;
    apply_stimulus(16'h0401, 48);
    check_output("multi_flag", {3'b0, multi_key}, 4'h1);
    check_output("multi_no_strobe", 4'(latches), 4'h0);
    apply_stimulus(16'h0001, 64);
    check_output("multi_drop_strobes", 4'(latches), 4'h1);
    check_output("multi_drop_digit", user_digit, 4'h1);
    check_output("multi_flag_clear", {3'b0, multi_key}, 4'h0);
    apply_stimulus(16'h0000, 80);

    // rollover r0c3 -> r3c2
    latches = 0;
    apply_stimulus(16'h0008, 64);
    check_output("roll_first_strobe", 4'(latches), 4'h1);
    check_output("roll_first_digit", user_digit, 4'hA);
    latches = 0;
    apply_stimulus(16'h4008, 48);
    apply_stimulus(16'h4000, 64);
    apply_stimulus(16'h0000, 64);
    check_output("roll_no_strobe", 4'(latches), 4'h0);
    apply_stimulus(16'h4000, 64);
    check_output("roll_fresh_strobe", 4'(latches), 4'h1);
    check_output("roll_fresh_digit", user_digit, 4'hF);
    apply_stimulus(16'h0000, 80);

    // enable drop during debounce of r2c0
    align();
    latches = 0;
    apply_stimulus(16'h0100, 16);
    enable = 1'b0;
    step();
    check_output("en_col_off", col_out, 4'hF);
    check_output("en_key_down", {3'b0, key_down}, 4'h0);
    run(20);
    check_output("en_no_strobe", 4'(latches), 4'h0);
    check_output("en_digit_held", user_digit, 4'hF);
    enable = 1'b1;
    run(64);
    check_output("en_strobes", 4'(latches), 4'h1);
    check_output("en_digit", user_digit, 4'h7);
    apply_stimulus(16'h0000, 80);

    // random key traffic with occasional bounce and enable drops
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: pat = 16'(1) << $urandom_range(0, 15);
        5:             pat = 16'h0;
        6:             pat = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: begin
          pat = keys;
          enable = 1'b0;
        end
      endcase
      keys = pat;
      for (int i = 0; i < int'($urandom_range(8, 120)); i++) begin
        step();
        if ($urandom_range(0, 15) == 0) keys = keys ^ (16'(1) << $urandom_range(0, 15));
      end
      enable = 1'b1;
    end
    apply_stimulus(16'h0000, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otp_keypad_entry.md
# otp_keypad_entry

User-side digit source for the OTP authentication path: scans a 4x4 active-low matrix keypad, debounces presses, and delivers each accepted key as a 4-bit digit with a single-cycle strobe. It sits between the keypad pins and the authentication FSM, and drives that FSM's `user_digit`/`user_latch` inputs. One physical press yields exactly one strobe.

## Interface
- `SCAN_DIV`, default 50_000: clk cycles each column is driven (≥4).
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results required to accept a press or a release (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `enable`  in  1  high = scanning active; low = synchronous return to idle.
- `row_in`  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- `col_out`  out  4  column drive, active-low, at most one bit low.
- `user_digit`  out  4  last accepted key code; holds between presses.
- `user_latch`  out  1  one-cycle pulse, coincident with a new `user_digit`.
- `key_down`  out  1  high in PRESSED and RELEASE states.
- `multi_key`  out  1  high while the most recent scan saw more than one key.

## Operation
- `row_in` passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Column index `c` cycles 0→1→2→3→0. Each column is driven (`col_out` = ~(1<<c)) for `SCAN_DIV` cycles.
- Rows are sampled on the last cycle of each column slot (slot counter == `SCAN_DIV`-1), into a 16-bit scan image.
- After the column-3 sample, the scan is classified as one of: EMPTY, SINGLE(code), or MULTI (≥2 bits set).
- Key code map, row r / column c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- States:
  - IDLE: SINGLE(k) → DEBOUNCE, candidate=k, count=1. EMPTY and MULTI stay in IDLE.
  - DEBOUNCE:
    - SINGLE(candidate) increments count. When count reaches `DEBOUNCE_SCANS` → PRESSED, `user_digit`=candidate, `user_latch`=1 for one cycle.
    - SINGLE(other k) → restart with candidate=k, count=1.
    - EMPTY or MULTI → IDLE.
  - PRESSED: EMPTY → RELEASE, rcount=1. Anything else stays in PRESSED with no further strobe, so a held key, a rollover to another key, and MULTI are all ignored.
  - RELEASE:
    - EMPTY increments rcount. When rcount reaches `DEBOUNCE_SCANS` → IDLE.
    - Any non-EMPTY result → PRESSED (bounce; no strobe).
- `DEBOUNCE_SCANS`=1: a single SINGLE scan from IDLE goes directly to PRESSED with a strobe, and a single EMPTY scan from PRESSED goes directly to IDLE.
- `multi_key` updates at every classification and reflects only the latest scan.
- `enable` low, on any cycle:
  - next cycle: state=IDLE, counters and column index = 0, `col_out`=4'b1111, `multi_key`=0, no strobe.
  - `user_digit` holds.
  - When `enable` rises, scanning restarts at column 0, slot count 0. A key already held is accepted normally after debounce.
- Async reset values: state IDLE, `col_out`=4'b1111, `user_digit`=0, `user_latch`=0, `key_down`=0, `multi_key`=0, all counters 0, synchronizer flops = 4'b1111.

## Timing
- Full scan period = 4×`SCAN_DIV` cycles.
- `col_out` changes on the cycle after the slot counter wraps. The 2-flop synchronizer plus `SCAN_DIV`≥4 guarantees settled rows at sample time.
- Classification happens and the state updates in the cycle after the column-3 sample. `user_latch` is registered and is high in the cycle following that update, together with the new `user_digit`.
- Press-to-strobe latency for a clean press: between (`DEBOUNCE_SCANS`)×4×`SCAN_DIV` and (`DEBOUNCE_SCANS`+1)×4×`SCAN_DIV` + 4 cycles.
- Strobes are spaced at least (2×`DEBOUNCE_SCANS`)×4×`SCAN_DIV` cycles apart.
- `user_latch` is never high in two consecutive cycles.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=2, scan = 16 cycles.

- Reset check: assert reset mid-scan → all outputs at reset values immediately. On release with `enable`=1, `col_out` steps 1110→1101→1011→0111, each held 4 cycles.
- Clean press: hold key r1c1 for 200 cycles, then release for 100 cycles → exactly one `user_latch` pulse with `user_digit`=4'h5, within 48 cycles of press; `key_down` falls ≥32 cycles after release.
- Bounce: r3c1 toggles every 3 cycles for 40 cycles, then held stable → a single strobe with `user_digit`=4'h0, none during the bounce. Release with a 1-scan glitch back to pressed → no second strobe.
- Multi-key: r0c0 and r2c2 held together → `multi_key`=1, no strobe. Drop r2c2 → one strobe with `user_digit`=4'h1, and `multi_key` returns to 0.
- Rollover: hold r0c3 (strobe 4'hA), then press r3c2 while r0c3 is still held, then release r0c3 → no strobe until both keys are released and r3c2 is pressed afresh.
- Enable drop: deassert `enable` during DEBOUNCE of r2c0 → `col_out`=1111 next cycle, no strobe. Reassert with the key still held → strobe 4'h7 after debounce; `user_digit` held its prior value throughout.
